// File: rtl/fpga_ip_demo_onchip_mem_arbiter.sv
// rtl/fpga_ip_demo_onchip_mem_arbiter.sv - round-robin two-master arbiter for a single-port on-chip RAM
module fpga_ip_demo_onchip_mem_arbiter #(
    parameter int DEPTH = 5120,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_address,
    input  logic [3:0]    m0_byteenable,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [31:0]   m0_writedata,
    output logic          m0_waitrequest,
    output logic [31:0]   m0_readdata,
    output logic          m0_readdatavalid,
    output logic          m0_err,
    input  logic [AW-1:0] m1_address,
    input  logic [3:0]    m1_byteenable,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [31:0]   m1_writedata,
    output logic          m1_waitrequest,
    output logic [31:0]   m1_readdata,
    output logic          m1_readdatavalid,
    output logic          m1_err,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    input  logic [31:0]   mem_readdata
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic          req0, req1;
    logic          gnt0, gnt1, granted;
    logic          last_gnt;
    logic [AW-1:0] sel_address;
    logic          sel_write;
    logic          sel_read;
    logic          in_range;
    logic          rd_pend, rd_port, rd_oor;
    logic          err0, err1;

    // On a tie the port that did not win last time gets the slot.
    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        gnt0    = ~reset & req0 & (~req1 | last_gnt);
        gnt1    = ~reset & req1 & (~req0 | ~last_gnt);
        granted = gnt0 | gnt1;
    end

    always_comb begin
        sel_address    = gnt1 ? m1_address    : m0_address;
        mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
        mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
        sel_write      = gnt1 ? m1_write      : m0_write;
        in_range       = {1'b0, sel_address} < DEPTH_W;
        sel_read       = granted & ~sel_write;
        mem_address    = sel_address;
        mem_chipselect = granted & in_range;
        mem_write      = granted & sel_write & in_range;
        m0_waitrequest = ~gnt0;
        m1_waitrequest = ~gnt1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
            rd_pend  <= 1'b0;
            rd_port  <= 1'b0;
            rd_oor   <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            if (granted) begin
                last_gnt <= gnt1;
            end
            rd_pend <= sel_read;
            rd_port <= gnt1;
            rd_oor  <= ~in_range;
            if (gnt0 & ~in_range) begin
                err0 <= 1'b1;
            end
            if (gnt1 & ~in_range) begin
                err1 <= 1'b1;
            end
        end
    end

    // Gating with reset drops a read that was in flight when reset arrived.
    always_comb begin
        m0_readdatavalid = rd_pend & ~rd_port & ~reset;
        m1_readdatavalid = rd_pend & rd_port & ~reset;
        m0_readdata      = rd_oor ? 32'h0 : mem_readdata;
        m1_readdata      = rd_oor ? 32'h0 : mem_readdata;
        m0_err           = err0;
        m1_err           = err1;
    end
endmodule

// File: doc/fpga_ip_demo_onchip_mem_arbiter.md
# fpga_ip_demo_onchip_mem_arbiter

Two-requester Avalon-MM arbiter that shares the single-port 32-bit on-chip memory (5120 words, 13-bit word address, byte enables, 1-cycle read latency) between two masters. Examples are a CPU data port and a DMA engine. Grants are round-robin at one access per cycle. The block generates per-requester waitrequest/readdatavalid, blocks out-of-range accesses, and records them in sticky error flags. It sits between the two masters and the memory's s1 slave.

## Interface
- DEPTH, 5120: number of valid words; addresses >= DEPTH are out of range.
- AW, 13: word address width.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- mN_address  in  AW  word address, for N = 0 and 1.
- mN_byteenable  in  4  byte lanes, for N = 0 and 1.
- mN_read, mN_write  in  1  request strobes, held until accepted.
- mN_writedata  in  32  write data.
- mN_waitrequest  out  1  high means the request is not accepted this cycle.
- mN_readdata  out  32  read data, qualified by mN_readdatavalid.
- mN_readdatavalid  out  1  one pulse per accepted read.
- mN_err  out  1  sticky out-of-range flag for port N.
- mem_address  out  AW  to memory address.
- mem_byteenable  out  4  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  32  to memory writedata.
- mem_readdata  in  32  from memory readdata (unregistered q).

## Operation
- **Request definition:** reqN = mN_read | mN_write. A request is accepted in a cycle when reqN is high and mN_waitrequest is low.
- **Arbitration (combinational):**
  - Only one requester active: that requester is granted.
  - Both active: grant the port that was not granted last (register last_gnt).
  - last_gnt updates on every accepted request.
  - After reset, last_gnt = 1, so m0 wins the first tie.
- **waitrequest:**
  - mN_waitrequest = ~gntN.
  - The non-granted port sees waitrequest high only while it is requesting; when idle it may be high or low (don't care).
  - During reset, both waitrequests are high.
- **Memory drive:**
  - mem_address, mem_byteenable and mem_writedata come from the granted port.
  - mem_chipselect = granted & in_range.
  - mem_write = granted write & in_range.
  - When no port is granted, chipselect and write are 0.
- **Read/write on one port:** if a port asserts mN_read and mN_write together, it is treated as a write; no readdatavalid is generated.
- **Out-of-range access (address >= DEPTH):**
  - The request is still accepted (waitrequest low when granted), so the master never hangs.
  - The memory is not selected and writes are dropped.
  - A read returns 32'h0 with a normal readdatavalid.
  - mN_err is set and stays set until reset.
- **Read return tracking:**
  - Registered rd_pend, rd_port and rd_oor capture each accepted read.
  - In the next cycle, the port named by rd_port gets readdatavalid = 1.
  - That port's readdata = rd_oor ? 0 : mem_readdata.
  - The other port's readdata is don't care; readdatavalid is 0.

## Timing
- **Write:** accepted in cycle T and committed to memory at the clock edge ending T.
- **Read:** accepted in cycle T, readdatavalid and data in cycle T+1. Fixed latency 1; reads pipeline back-to-back at one per cycle.
- **Read after write, same address:** write accepted at T, read accepted at T+1. The read returns the new data at T+2.
- **Throughput and fairness:** at most one access per cycle in total. With both ports requesting continuously, grants alternate m0, m1, m0, ... Maximum wait is 1 cycle.
- **Reset values:**
  - mN_waitrequest = 1, mN_readdatavalid = 0, mN_err = 0.
  - mem_chipselect = 0, mem_write = 0.
  - rd_pend = 0, last_gnt = 1.
- **Reset mid-operation:** reset asserted in cycle T+1 after a read accepted in T suppresses that readdatavalid. The pending read is discarded.
- **First cycle after reset deasserts:** requests may be granted in that same cycle.

## Test plan
- **Reset:** hold reset for 3 cycles with both ports requesting -> both waitrequest = 1, no mem_chipselect, readdatavalid = 0, err = 0.
- **Single-port round trip:**
  - m0 writes 0xDEADBEEF to address 0x10 with byteenable 4'b1111, then 0x0000_00AA with byteenable 4'b0001.
  - m0 then reads 0x10 -> readdatavalid one cycle after acceptance, data 0xDEADBEAA.
- **Contention:**
  - Both ports issue 4 back-to-back reads to distinct preloaded addresses from the same cycle.
  - Expect grants in order m0, m1, m0, m1, m0, m1, m0, m1.
  - Each readdatavalid goes to the correct port with matching data; no lost or duplicated pulses.
- **Out of range:**
  - m1 writes 0x12345678 to address 5120 -> accepted, mem_chipselect = 0, m1_err = 1 and sticky.
  - m1 reads 8191 -> data 0 with readdatavalid; m0_err stays 0.
- **Read and write together:** m0 asserts read and write to address 0x20 with data 0x55 -> write performed, no readdatavalid; a later read of 0x20 returns 0x55.
- **Reset mid-read:** m0 read accepted at T, reset at T+1 -> no readdatavalid. After reset, m0 wins the first tie against m1.
